// File: rtl/pwm_capture_channel_pkg.sv
// pwm_capture_channel_pkg: register map, status bit layout and divider states
package pwm_capture_channel_pkg;
    localparam int DutyW = 8;
    localparam logic [1:0] PwmCapAdrDuty   = 2'd0;
    localparam logic [1:0] PwmCapAdrStatus = 2'd1;
    localparam logic [1:0] PwmCapAdrPerLo  = 2'd2;
    localparam logic [1:0] PwmCapAdrPerHi  = 2'd3;
    localparam int StValid   = 0;
    localparam int StStale   = 1;
    localparam int StPwm     = 2;
    localparam int StOvf     = 3;
    localparam int OvfClrBit = 2;
    typedef enum logic {DivIdle, DivRun} div_state_e;
endpackage

// File: rtl/pwm_capture_channel_if.sv
// pwm_capture_channel_if: single-cycle Wishbone register port of the capture channel
interface pwm_capture_channel_if;
    logic       stb;
    logic       we;
    logic [1:0] adr;
    logic [7:0] dat_w;
    logic [7:0] dat_r;
    logic       ack;
    modport master (output stb, we, adr, dat_w, input dat_r, ack);
    modport slave  (input stb, we, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/pwm_capture_div.sv
// pwm_capture_div: restoring divider producing high*256/period as an 8-bit fraction
module pwm_capture_div
    import pwm_capture_channel_pkg::*;
#(
    parameter int CntW = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CntW-1:0]  i_num,
    input  logic [CntW-1:0]  i_den,
    output logic             o_busy,
    output logic             o_done,
    output logic [DutyW-1:0] o_quo
);
    div_state_e       r_state;
    logic [CntW:0]    r_rem;
    logic [CntW-1:0]  r_den;
    logic [DutyW-1:0] r_quo;
    logic [2:0]       r_iter;
    logic             r_done;
    logic [CntW:0]    w_sh;
    logic             w_ge;

    assign w_sh   = {r_rem[CntW-1:0], 1'b0};
    assign w_ge   = w_sh >= {1'b0, r_den};
    assign o_busy = r_state == DivRun;
    assign o_done = r_done;
    assign o_quo  = r_quo;

    // Load operands on start (a new start always wins), else shift one quotient bit per cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= DivIdle;
            r_rem   <= '0;
            r_den   <= '0;
            r_quo   <= '0;
            r_iter  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_den  <= i_den;
                r_rem  <= {1'b0, i_num};
                r_iter <= 3'd7;
                if (i_num >= i_den) begin
                    r_quo   <= '1;
                    r_done  <= 1'b1;
                    r_state <= DivIdle;
                end else begin
                    r_state <= DivRun;
                end
            end else if (i_abort) begin
                r_state <= DivIdle;
            end else if (r_state == DivRun) begin
                r_rem  <= w_ge ? w_sh - {1'b0, r_den} : w_sh;
                r_quo  <= {r_quo[DutyW-2:0], w_ge};
                r_iter <= r_iter - 3'd1;
                if (r_iter == 3'd0) begin
                    r_state <= DivIdle;
                    r_done  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pwm_capture_channel.sv
// pwm_capture_channel: measures period/high time of pwm_i and exposes duty over Wishbone
module pwm_capture_channel
    import pwm_capture_channel_pkg::*;
#(
    parameter int CntW       = 16,
    parameter int SyncStages = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 pwm_i,
    pwm_capture_channel_if.slave wb
);
    localparam logic [CntW-1:0] CntMax = '1;

    logic [SyncStages-1:0] r_sync;
    logic                  r_pwm_d;
    logic [CntW-1:0]       r_cnt;
    logic [CntW-1:0]       r_hi;
    logic [CntW-1:0]       r_period;
    logic [CntW-9:0]       r_shadow;
    logic [DutyW-1:0]      r_duty;
    logic                  r_valid;
    logic                  r_stale;
    logic                  r_ovf;
    logic                  r_armed;
    logic                  w_pwm_s;
    logic                  w_rise;
    logic                  w_sat;
    logic                  w_meas;
    logic                  w_timeout;
    logic                  w_rd_perlo;
    logic                  w_ovf_clr;
    logic                  w_busy;
    logic                  w_done;
    logic [DutyW-1:0]      w_quo;
    logic [7:0]            w_status;
    logic                  w_unused;

    assign w_pwm_s    = r_sync[SyncStages-1];
    assign w_rise     = w_pwm_s & ~r_pwm_d;
    assign w_sat      = r_cnt == CntMax;
    assign w_meas     = w_rise & r_armed & ~w_sat;
    assign w_timeout  = w_sat & ~w_rise;
    assign w_rd_perlo = wb.stb & ~wb.we & (wb.adr == PwmCapAdrPerLo);
    assign w_ovf_clr  = wb.stb & wb.we & (wb.adr == PwmCapAdrStatus) & wb.dat_w[OvfClrBit];
    assign w_unused   = ^{wb.dat_w[7:OvfClrBit+1], wb.dat_w[OvfClrBit-1:0]};

    pwm_capture_div #(.CntW(CntW)) u_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_start(w_meas),
        .i_abort(w_timeout & w_busy),
        .i_num  (r_hi),
        .i_den  (r_cnt),
        .o_busy (w_busy),
        .o_done (w_done),
        .o_quo  (w_quo)
    );

    // Bring pwm_i into the clock domain and keep last level for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync  <= '0;
            r_pwm_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SyncStages-2:0], pwm_i};
            r_pwm_d <= w_pwm_s;
        end
    end

    // Period and high-time counters restart at each rise (the rise cycle counts as 1)
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_hi  <= '0;
        end else if (w_rise) begin
            r_cnt <= CntW'(1);
            r_hi  <= CntW'(1);
        end else begin
            r_cnt <= w_sat ? r_cnt : r_cnt + CntW'(1);
            r_hi  <= (r_hi == CntMax) ? r_hi : r_hi + CntW'(w_pwm_s);
        end
    end

    // Capture a measurement on an armed rise; a saturated count marks the input stale
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_period <= '0;
            r_valid  <= 1'b0;
            r_stale  <= 1'b1;
            r_armed  <= 1'b0;
            r_ovf    <= 1'b0;
            r_duty   <= '0;
        end else begin
            if (w_meas) begin
                r_period <= r_cnt;
                r_valid  <= 1'b1;
                r_stale  <= 1'b0;
            end else if (w_timeout) begin
                r_period <= CntMax;
                r_stale  <= 1'b1;
            end
            r_armed <= w_rise ? 1'b1 : w_timeout ? 1'b0 : r_armed;
            r_ovf   <= w_timeout ? 1'b1 : w_ovf_clr ? 1'b0 : r_ovf;
            r_duty  <= w_timeout ? {DutyW{w_pwm_s}} : w_done ? w_quo : r_duty;
        end
    end

    // Reading the low period byte freezes the upper bits for a coherent follow-up read
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shadow <= '0;
        end else if (w_rd_perlo) begin
            r_shadow <= r_period[CntW-1:8];
        end
    end

    // Assemble the status register from its individual flags
    always_comb begin
        w_status          = '0;
        w_status[StValid] = r_valid;
        w_status[StStale] = r_stale;
        w_status[StPwm]   = w_pwm_s;
        w_status[StOvf]   = r_ovf;
    end

    assign wb.ack   = wb.stb;
    assign wb.dat_r = !wb.stb                      ? 8'h00 :
                      (wb.adr == PwmCapAdrDuty)    ? r_duty :
                      (wb.adr == PwmCapAdrStatus)  ? w_status :
                      (wb.adr == PwmCapAdrPerLo)   ? r_period[7:0] :
                                                     r_shadow[7:0];
endmodule

// File: tb/tb_pwm_capture_channel.sv
// tb_pwm_capture_channel: randomized PWM capture bench with timestamp-based reference model
module tb_pwm_capture_channel;
    localparam int Max = 65535;

    typedef struct {
        logic [1:0] a;
        logic [7:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm = 1'b0;
    bit   lvl = 1'b0;
    bit   in_rst;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    bit ph[$];
    int pre[$];
    int c;
    int m_duty, m_period, m_shadow, m_base, pend_t, pend_v;
    bit m_valid, m_stale, m_ovf, m_armed;

    pwm_capture_channel_if wb();

    pwm_capture_channel #(.CntW(16), .SyncStages(2)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .pwm_i(pwm),
        .wb   (wb)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        ph.delete();
        pre.delete();
        pre.push_back(0);
        c        = 0;
        m_duty   = 0;
        m_period = 0;
        m_shadow = 0;
        m_base   = 0;
        pend_t   = -1;
        pend_v   = 0;
        m_valid  = 1'b0;
        m_stale  = 1'b1;
        m_ovf    = 1'b0;
        m_armed  = 1'b0;
    endfunction

    // synchronised level seen by the DUT in cycle k: the input driven two cycles earlier
    function automatic bit ps(input int k);
        return (k >= 2) ? ph[k-2] : 1'b0;
    endfunction

    task automatic step(input bit pw, input bit stb, input bit we, input logic [1:0] adr,
                        input logic [7:0] dat, input bit rel);
        int cnt, hh;
        bit s, rise, sat;
        logic [7:0] e;
        @(posedge clk);
        #1;
        if (rel) begin
            rst    = 1'b0;
            in_rst = 1'b0;
        end
        pwm      = pw;
        wb.stb   = stb;
        wb.we    = we;
        wb.adr   = adr;
        wb.dat_w = dat;
        if (in_rst) begin
            if (stb && !we) exp_q.push_back('{adr, (adr == 2'd1) ? 8'h02 : 8'h00});
            return;
        end
        ph.push_back(pw);
        s = ps(c);
        if (stb && !we) begin
            e = (adr == 2'd0) ? 8'(m_duty) :
                (adr == 2'd1) ? {4'b0, m_ovf, s, m_stale, m_valid} :
                (adr == 2'd2) ? 8'(m_period) : 8'(m_shadow);
            exp_q.push_back('{adr, e});
        end
        if (pend_t >= 0 && pend_t <= c + 1) begin
            m_duty = pend_v;
            pend_t = -1;
        end
        cnt  = (c - m_base > Max) ? Max : c - m_base;
        rise = s && !ps(c - 1);
        sat  = cnt == Max;
        if (stb && !we && adr == 2'd2) m_shadow = m_period >> 8;
        if (rise) begin
            if (m_armed && !sat) begin
                hh       = pre[c] - pre[m_base];
                m_period = cnt;
                m_valid  = 1'b1;
                m_stale  = 1'b0;
                pend_v   = (hh >= cnt) ? 255 : hh * 256 / cnt;
                pend_t   = (hh >= cnt) ? c + 2 : c + 10;
            end
            m_armed = 1'b1;
            m_base  = c;
        end else if (sat) begin
            m_stale  = 1'b1;
            m_armed  = 1'b0;
            m_ovf    = 1'b1;
            m_period = Max;
            m_duty   = s ? 255 : 0;
            pend_t   = -1;
        end
        if (stb && we && adr == 2'd1 && dat[2] && !(sat && !rise)) m_ovf = 1'b0;
        pre.push_back(pre[c] + int'(s));
        c++;
    endtask

    task automatic rd(input logic [1:0] a);
        step(lvl, 1'b1, 1'b0, a, 8'h00, 1'b0);
    endtask

    // drive n cycles of a period-p/high-h waveform; rate 0 = no bus traffic, amode 4 = random address
    task automatic run(input int p, input int h, input int n, input int rate, input int amode);
        for (int k = 0; k < n; k++) begin
            bit pw;
            int a;
            bit w;
            pw  = (k % p) < h;
            lvl = pw;
            if (rate > 0 && $urandom_range(rate - 1) == 0) begin
                a = (amode == 4) ? int'($urandom_range(3)) : amode;
                w = (amode == 4) && ($urandom_range(3) == 0);
                step(pw, 1'b1, w, 2'(a), 8'($urandom), 1'b0);
            end else begin
                step(pw, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
            end
        end
    endtask

    task automatic async_reset();
        #1 rst = 1'b1;
        in_rst = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        lvl = 1'b0;
    endtask

    // monitor: every acked read pops the next expected value
    always @(negedge clk) begin
        if (wb.stb || wb.ack) begin
            checks++;
            if (wb.ack !== wb.stb) begin
                errors++;
                $display("FAIL ack: got %b need %b at cycle %0d", wb.ack, wb.stb, c);
            end
        end
        if (wb.ack && !wb.we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read: unexpected data %h at cycle %0d", wb.dat_r, c);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (wb.dat_r !== e.v) begin
                    errors++;
                    $display("FAIL reg%0d at cycle %0d: got %h need %h", e.a, c, wb.dat_r, e.v);
                end
            end
        end
    end

    initial begin
        in_rst   = 1'b1;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.adr   = 2'd0;
        wb.dat_w = 8'h00;
        model_reset();
        rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        step(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        run(100, 25, 400, 4, 4);
        rd(2'd2); rd(2'd3); rd(2'd0); rd(2'd1);
        run(30, 0, 30, 0, 0);
        run(3, 1, 6, 1, 0);
        run(15, 0, 15, 1, 0);
        repeat (6) begin
            int p, h;
            p = $urandom_range(300, 12);
            h = $urandom_range(p - 1, 1);
            run(p, h, 3 * p, 6, 4);
        end
        run(100, 50, 300, 3, 4);
        run(200, 50, 600, 1, 0);
        run(16'h1234, 100, 16'h1234, 0, 0);
        run(30, 30, 30, 0, 0);
        rd(2'd2);
        run(69960, 69960, 69960, 0, 0);
        rd(2'd3); rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
        run(100, 50, 350, 1, 4);
        step(lvl, 1'b1, 1'b1, 2'd1, 8'h04, 1'b0);
        rd(2'd1);
        run(100, 25, 200, 4, 4);
        run(100, 25, 6, 0, 0);
        async_reset();
        run(20, 0, 20, 1, 0);
        run(5, 0, 5, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d reads never acked, need 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
